// File: rtl/mips_bus_pkg.sv
// -----------------------------------------------------------------------------
// mips_bus_pkg
// Shared definitions for the MIPS two-master bus arbiter:
//   - default address/data widths
//   - master index constants (M0 = instruction fetch, M1 = data)
//   - arbiter state enum (IDLE, GRANT0, GRANT1)
//   - mips_bus_arb_pick: one-cycle arbitration decision taken in IDLE
// Build option: define MIPS_BUS_ARB_ROUND_ROBIN_EN to resolve simultaneous
// requests round-robin (away from last_grant). Without it, m1 always wins ties.
// -----------------------------------------------------------------------------
package mips_bus_pkg;

    localparam int MIPS_ADDR_W = 32;
    localparam int MIPS_DATA_W = 32;

    // Master indices as stored in last_grant
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
    localparam logic ARB_RR_EN = 1'b1;
`else
    localparam logic ARB_RR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    // Next owner chosen from IDLE. On a tie, round-robin hands the bus to the
    // master that did not own it last; fixed priority always favours m1.
    function automatic arb_state_t mips_bus_arb_pick(
        input logic req0,
        input logic req1,
        input logic last_grant
    );
        arb_state_t pick;
        case ({req1, req0})
            2'b01:   pick = GRANT0;
            2'b10:   pick = GRANT1;
            2'b11: begin
                if (ARB_RR_EN && (last_grant == M1)) begin
                    pick = GRANT0;
                end else begin
                    pick = GRANT1;
                end
            end
            default: pick = IDLE;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
// Arbitrates an instruction-fetch master (m0) and a data master (m1) onto one
// Avalon-style slave port. A grant is issued one cycle after a request is seen
// in IDLE, held until the transfer completes (owner requesting and slave not
// waiting) or the owner drops its request, and then the bus returns to IDLE.
// Build option: MIPS_BUS_ARB_ROUND_ROBIN_EN (see mips_bus_pkg).
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   m0_* / m1_*           master address/read/write/writedata/byteenable in,
//                         waitrequest/readdata out
//   s_*                   slave address/read/write/writedata/byteenable out,
//                         waitrequest/readdata in
//   grant                 one-hot owner (bit0 = m0, bit1 = m1), 0 when idle
// -----------------------------------------------------------------------------
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W = MIPS_ADDR_W,
    parameter int DATA_W = MIPS_DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,

    output logic [ADDR_W-1:0]     s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    input  logic                  s_waitrequest,
    input  logic [DATA_W-1:0]     s_readdata,

    output logic [1:0]            grant
);

    arb_state_t state_r;
    arb_state_t state_next_s;
    logic       last_grant_r;
    logic       last_grant_next_s;
    logic       req0_s;
    logic       req1_s;

    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

    // Read data is broadcast; only the granted master sees waitrequest low.
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    // State and last-owner registers; reset abandons any transfer at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            last_grant_r <= M1;
        end else begin
            state_r      <= state_next_s;
            last_grant_r <= last_grant_next_s;
        end
    end

    // Next-state logic: every grant ends in IDLE on completion or abort.
    always_comb begin
        state_next_s      = state_r;
        last_grant_next_s = last_grant_r;
        case (state_r)
            IDLE: begin
                state_next_s = mips_bus_arb_pick(req0_s, req1_s, last_grant_r);
            end
            GRANT0: begin
                if (!req0_s || !s_waitrequest) begin
                    state_next_s      = IDLE;
                    last_grant_next_s = M0;
                end else begin
                    state_next_s      = GRANT0;
                end
            end
            GRANT1: begin
                if (!req1_s || !s_waitrequest) begin
                    state_next_s      = IDLE;
                    last_grant_next_s = M1;
                end else begin
                    state_next_s      = GRANT1;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output mux: slave signals follow the owner combinationally; read+write
    // together from one master is issued as a write only.
    always_comb begin
        s_address      = {ADDR_W{1'b0}};
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = {DATA_W{1'b0}};
        s_byteenable   = {(DATA_W/8){1'b0}};
        grant          = 2'b00;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        case (state_r)
            GRANT0: begin
                s_address      = m0_address;
                s_read         = m0_read & ~m0_write;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                grant          = 2'b01;
                m0_waitrequest = s_waitrequest;
            end
            GRANT1: begin
                s_address      = m1_address;
                s_read         = m1_read & ~m1_write;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                grant          = 2'b10;
                m1_waitrequest = s_waitrequest;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mips_bus_arbiter
// Table-driven cycle vectors for mips_bus_arbiter plus a hand-written
// asynchronous-reset sequence. Inputs change on the falling edge; outputs are
// compared 2 time units later, well clear of the rising edge.
// Expectations follow the build option MIPS_BUS_ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_mips_bus_arbiter;

    localparam logic [31:0] A0  = 32'hBFC00000;
    localparam logic [31:0] A1  = 32'hBFC00100;
    localparam logic [31:0] D1  = 32'hDEADBEEF;
    localparam logic [31:0] D2  = 32'hCAFEF00D;
    localparam logic [31:0] W0  = 32'h11112222;
    localparam logic [3:0]  BE0 = 4'h3;
    localparam logic [3:0]  BE1 = 4'hF;
    localparam int          NV  = 27;

    typedef struct {
        logic        m0_rd;
        logic        m0_wr;
        logic        m1_rd;
        logic        m1_wr;
        logic [31:0] m1_wdata;
        logic        s_wait;
        logic [1:0]  e_grant;
        logic        e_srd;
        logic        e_swr;
        logic [31:0] e_saddr;
        logic [31:0] e_swdata;
        logic [3:0]  e_sbe;
        logic        e_m0w;
        logic        e_m1w;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] m0_address;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_writedata;
    logic [3:0]  m0_byteenable;
    logic        m0_waitrequest;
    logic [31:0] m0_readdata;
    logic [31:0] m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [3:0]  m1_byteenable;
    logic        m1_waitrequest;
    logic [31:0] m1_readdata;
    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs [NV];

    mips_bus_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_byteenable  (m0_byteenable),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_byteenable  (m1_byteenable),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_byteenable   (s_byteenable),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .grant          (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare the idle-bus output set (no owner, no strobes, both waiting).
    task automatic chk_idle(input string tag);
        chk({tag, " grant"},  {30'd0, grant}, 32'd0);
        chk({tag, " s_read"}, {31'd0, s_read}, 32'd0);
        chk({tag, " s_write"}, {31'd0, s_write}, 32'd0);
        chk({tag, " s_address"}, s_address, 32'd0);
        chk({tag, " s_writedata"}, s_writedata, 32'd0);
        chk({tag, " s_byteenable"}, {28'd0, s_byteenable}, 32'd0);
        chk({tag, " m0_wait"}, {31'd0, m0_waitrequest}, 32'd1);
        chk({tag, " m1_wait"}, {31'd0, m1_waitrequest}, 32'd1);
    endtask

    initial begin
        // m0_rd m0_wr m1_rd m1_wr m1_wdata s_wait | grant srd swr saddr swdata sbe m0w m1w
        // Contention straight after reset (last_grant = m1)
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,D1,1'b0, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,D1,1'b0, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,D1,1'b0, 2'b01,1'b1,1'b0,A0,W0,BE0,1'b0,1'b1};
`else
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b1,D1,1'b0, 2'b10,1'b0,1'b1,A1,D1,BE1,1'b1,1'b0};
`endif
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b1,D1,1'b0, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b1,D1,1'b0, 2'b10,1'b0,1'b1,A1,D1,BE1,1'b1,1'b0};
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,D1,1'b0, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,D1,1'b0, 2'b01,1'b1,1'b0,A0,W0,BE0,1'b0,1'b1};
        // Single read, zero wait states
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,D1,1'b0, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,D1,1'b0, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,D1,1'b0, 2'b01,1'b1,1'b0,A0,W0,BE0,1'b0,1'b1};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,D1,1'b0, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        // Three wait states with m1 pending throughout
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,D1,1'b1, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b1,D1,1'b1, 2'b01,1'b1,1'b0,A0,W0,BE0,1'b1,1'b1};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b1,D1,1'b1, 2'b01,1'b1,1'b0,A0,W0,BE0,1'b1,1'b1};
        vecs[14] = '{1'b1,1'b0,1'b0,1'b1,D1,1'b1, 2'b01,1'b1,1'b0,A0,W0,BE0,1'b1,1'b1};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b1,D1,1'b0, 2'b01,1'b1,1'b0,A0,W0,BE0,1'b0,1'b1};
        vecs[16] = '{1'b0,1'b0,1'b0,1'b1,D1,1'b0, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        vecs[17] = '{1'b0,1'b0,1'b0,1'b1,D1,1'b0, 2'b10,1'b0,1'b1,A1,D1,BE1,1'b1,1'b0};
        // Master abort while slave is waiting
        vecs[18] = '{1'b1,1'b0,1'b0,1'b0,D1,1'b1, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        vecs[19] = '{1'b1,1'b0,1'b0,1'b0,D1,1'b1, 2'b01,1'b1,1'b0,A0,W0,BE0,1'b1,1'b1};
        vecs[20] = '{1'b0,1'b0,1'b0,1'b0,D1,1'b1, 2'b01,1'b0,1'b0,A0,W0,BE0,1'b1,1'b1};
        vecs[21] = '{1'b0,1'b0,1'b0,1'b0,D1,1'b1, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        // Read+write together is a write; then an m0 write
        vecs[22] = '{1'b0,1'b0,1'b1,1'b1,D2,1'b0, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        vecs[23] = '{1'b0,1'b0,1'b1,1'b1,D2,1'b0, 2'b10,1'b0,1'b1,A1,D2,BE1,1'b1,1'b0};
        vecs[24] = '{1'b0,1'b1,1'b0,1'b0,D2,1'b0, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};
        vecs[25] = '{1'b0,1'b1,1'b0,1'b0,D2,1'b0, 2'b01,1'b0,1'b1,A0,W0,BE0,1'b0,1'b1};
        vecs[26] = '{1'b0,1'b0,1'b0,1'b0,D2,1'b0, 2'b00,1'b0,1'b0,32'd0,32'd0,4'h0,1'b1,1'b1};

        // Reset held with requests present: bus must stay idle
        reset         = 1'b0;
        m0_address    = A0;
        m0_writedata  = W0;
        m0_byteenable = BE0;
        m1_address    = A1;
        m1_writedata  = D1;
        m1_byteenable = BE1;
        m0_read       = 1'b1;
        m0_write      = 1'b0;
        m1_read       = 1'b0;
        m1_write      = 1'b1;
        s_waitrequest = 1'b0;
        s_readdata    = 32'h0;
        repeat (2) @(negedge clk);
        #2;
        chk_idle("reset");

        @(negedge clk);
        reset    = 1'b1;
        m0_read  = 1'b0;
        m1_write = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            m0_read       = vecs[i].m0_rd;
            m0_write      = vecs[i].m0_wr;
            m1_read       = vecs[i].m1_rd;
            m1_write      = vecs[i].m1_wr;
            m1_writedata  = vecs[i].m1_wdata;
            s_waitrequest = vecs[i].s_wait;
            s_readdata    = $urandom;
            #2;
            chk($sformatf("v%0d grant", i), {30'd0, grant}, {30'd0, vecs[i].e_grant});
            chk($sformatf("v%0d s_read", i), {31'd0, s_read}, {31'd0, vecs[i].e_srd});
            chk($sformatf("v%0d s_write", i), {31'd0, s_write}, {31'd0, vecs[i].e_swr});
            chk($sformatf("v%0d s_address", i), s_address, vecs[i].e_saddr);
            chk($sformatf("v%0d s_writedata", i), s_writedata, vecs[i].e_swdata);
            chk($sformatf("v%0d s_byteenable", i), {28'd0, s_byteenable}, {28'd0, vecs[i].e_sbe});
            chk($sformatf("v%0d m0_wait", i), {31'd0, m0_waitrequest}, {31'd0, vecs[i].e_m0w});
            chk($sformatf("v%0d m1_wait", i), {31'd0, m1_waitrequest}, {31'd0, vecs[i].e_m1w});
            chk($sformatf("v%0d m0_readdata", i), m0_readdata, s_readdata);
            chk($sformatf("v%0d m1_readdata", i), m1_readdata, s_readdata);
        end

        // Async reset in the middle of a stalled m1 write
        @(negedge clk);
        m1_write      = 1'b1;
        m1_writedata  = D1;
        s_waitrequest = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_mid grant before", {30'd0, grant}, 32'd2);
        chk("rst_mid s_write before", {31'd0, s_write}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk_idle("rst_mid");

        // After release, a tie follows the reset value of last_grant (m1)
        @(negedge clk);
        reset         = 1'b1;
        m0_read       = 1'b1;
        m1_write      = 1'b1;
        s_waitrequest = 1'b0;
        #2;
        chk_idle("post_rst idle");
        @(negedge clk);
        #2;
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
        chk("post_rst first grant", {30'd0, grant}, 32'd1);
`else
        chk("post_rst first grant", {30'd0, grant}, 32'd2);
`endif

        @(negedge clk);
        m0_read  = 1'b0;
        m1_write = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of masters and slave.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have ports: clk input 1, single clock; reset input 1, asynchronous, active-low.
REQ-004 SHALL have ports m0_address in ADDR_W, m0_read in 1, m0_write in 1, m0_writedata in DATA_W, m0_byteenable in DATA_W/8, m0_waitrequest out 1, m0_readdata out DATA_W; m0 is the instruction-fetch master.
REQ-005 SHALL have an identical m1_* port set; m1 is the data master.
REQ-006 SHALL have ports s_address out ADDR_W, s_read out 1, s_write out 1, s_writedata out DATA_W, s_byteenable out DATA_W/8, s_waitrequest in 1, s_readdata in DATA_W; these drive the shared memory.
REQ-007 SHALL have port grant out 2, one-hot current owner (bit0 = m0, bit1 = m1), 2'b00 when idle.

Function
REQ-008 SHALL implement states IDLE, GRANT0, GRANT1, held in a state register.
REQ-009 A master requests when its read or write is high; read and write both high from one master SHALL be treated as a write.
REQ-010 IDLE: with any request, state SHALL move next edge to the GRANTx chosen by the arbitration rule; with no request, remain IDLE.
REQ-011 Grant latency SHALL be one cycle: request first seen in IDLE in cycle N reaches s_* in cycle N+1.
REQ-012 GRANTx: s_address, s_read, s_write, s_writedata, s_byteenable SHALL be combinationally muxed from master x.
REQ-013 IDLE: s_read and s_write SHALL be 0; s_address, s_writedata, s_byteenable SHALL be 0.
REQ-014 mX_waitrequest SHALL equal 1 unless state is GRANTx, in which case it SHALL equal s_waitrequest.
REQ-015 m0_readdata and m1_readdata SHALL both equal s_readdata; only the granted master may sample it.
REQ-016 Transfer completes in a GRANTx cycle where master x requests and s_waitrequest is 0; state SHALL return to IDLE next edge.
REQ-017 GRANTx with master x request low (master abort) SHALL return to IDLE next edge, no slave strobe issued that cycle.
REQ-018 Grant SHALL NOT change while s_waitrequest is 1 and owner still requests (no preemption, no timeout).
REQ-019 Simultaneous requests in IDLE SHALL be resolved per REQ-023/REQ-024; the loser keeps waitrequest 1 and is served after the next IDLE.
REQ-020 A register last_grant SHALL record the owner of the most recently completed or aborted grant.

Reset
REQ-021 While reset is 0: state IDLE, last_grant = m1, grant 2'b00, s_read 0, s_write 0, both mX_waitrequest 1, all other s_* outputs 0.
REQ-022 Reset asserted mid-transfer SHALL abandon it immediately (asynchronous); first grant after release follows REQ-010.

Configuration
REQ-023 With macro MIPS_BUS_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant goes to the master not equal to last_grant.
REQ-024 Without it: fixed priority, m1 (data) always wins simultaneous requests; last_grant still maintained.

Structure
REQ-025 A shared package mips_bus_pkg SHALL hold the state enum (IDLE, GRANT0, GRANT1), master index constants M0=0, M1=1, and default ADDR_W/DATA_W.
REQ-026 No sub-module; the one-cycle arbitration decision is a combinational function in the package (mips_bus_arb_pick).

Verification
REQ-027 Single read: m0_read=1, m0_address=32'hBFC00000, slave waitrequest 0 -> s_read high exactly one cycle after request, m0_waitrequest 0 that cycle, state back to IDLE.
REQ-028 Contention, RR build: m0_read and m1_write (addr 32'hBFC00100, data 32'hDEADBEEF, be 4'hF) same cycle after reset -> m0 granted first, m1 second, s_write carries 32'hDEADBEEF.
REQ-029 Contention, fixed-priority build: same stimulus -> m1 granted first, m0 second; m1 request repeated back-to-back starves m0 with m0_waitrequest held 1.
REQ-030 Wait states: slave holds s_waitrequest 1 for 3 cycles -> grant stable 4 cycles, m1 request pending throughout sees m1_waitrequest 1, then granted.
REQ-031 Async reset mid-transfer: reset low during GRANT1 with s_waitrequest 1 -> s_write 0 and grant 2'b00 before next clk edge.
REQ-032 Abort: m0 drops m0_read while GRANT0 and waitrequest 1 -> IDLE next edge, s_read 0.
